// File: rtl/outer_loop_ctrl_if.sv
// Outer-loop controller bus.
// Bundles the command side (start/abort/b), the inner-loop handshake
// (il_en/il_bi/il_en_out), the accumulator strobe and the status outputs.
//   master : the side that issues commands and models the inner loop
//   slave  : the outer_loop_ctrl block itself
interface outer_loop_ctrl_if #(
    parameter int Size    = 3072,
    parameter int Size_bi = 64
);
    logic               start;
    logic               abort;
    logic [Size-1:0]    b;
    logic               il_en;
    logic [Size_bi-1:0] il_bi;
    logic               il_en_out;
    logic               acc_en;
    logic [5:0]         round_idx;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, abort, b, il_en_out,
        input  il_en, il_bi, acc_en, round_idx, busy, done, err
    );

    modport slave (
        input  start, abort, b, il_en_out,
        output il_en, il_bi, acc_en, round_idx, busy, done, err
    );
endinterface

// File: rtl/outer_loop_ctrl.sv
// Outer-loop sequencer for a multi-round multiplier.
// On start, latches b and walks loop_round rounds: each round launches the
// inner loop with one radix-bit slice of b, waits (bounded by TIMEOUT) for
// its completion pulse, then strobes the accumulator.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   bus         outer_loop_ctrl_if.slave: start/abort/b in, inner-loop
//               handshake, acc_en, round_idx, busy/done/err status out
// Every output is decoded from registered state only.
module outer_loop_ctrl #(
    parameter int Size       = 3072,
    parameter int Size_bi    = 64,
    parameter int loop_round = 57,
    parameter int radix      = 54,
    parameter int TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    outer_loop_ctrl_if.slave bus
);
    localparam int BW = loop_round * radix;   // b zero-extended to whole slices
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACC, DONE, ERR} state_t;

    state_t          state_q, state_d;
    logic [5:0]      round_q, round_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [BW-1:0]   b_q, b_d;
    logic [radix-1:0] slice;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= '0;
            timer_q <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            timer_q <= timer_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        timer_d = timer_q;
        b_d     = b_q;
        if (bus.abort && state_q != IDLE) begin
            // abort beats completion, timeout and everything else
            state_d = IDLE;
            round_d = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        b_d     = BW'(bus.b[Size-1:0]);
                        round_d = '0;
                        timer_d = '0;
                        state_d = ISSUE;
                    end
                end
                ISSUE: state_d = WAIT;
                WAIT: begin
                    // a completion on the last allowed cycle still counts
                    if (bus.il_en_out)
                        state_d = ACC;
                    else if (timer_q == TW'(TIMEOUT - 1))
                        state_d = ERR;
                    else
                        timer_d = timer_q + 1'b1;
                end
                ACC: begin
                    if (round_q == 6'(loop_round - 1)) begin
                        state_d = DONE;
                    end else begin
                        round_d = round_q + 1'b1;
                        timer_d = '0;
                        state_d = ISSUE;
                    end
                end
                DONE: begin
                    round_d = '0;
                    state_d = IDLE;
                end
                ERR: begin
                    // start only clears the error here; a new run needs another start
                    if (bus.start) begin
                        round_d = '0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign slice = b_q[int'(round_q) * radix +: radix];

    // the slice is held from launch until the accumulator has captured
    assign bus.il_bi     = (state_q == ISSUE || state_q == WAIT || state_q == ACC)
                           ? Size_bi'(slice) : '0;
    assign bus.il_en     = (state_q == ISSUE);
    assign bus.acc_en    = (state_q == ACC);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = (state_q == ERR);
    assign bus.busy      = (state_q != IDLE);
    assign bus.round_idx = round_q;
endmodule

// File: tb/tb_outer_loop_ctrl.sv
module tb_outer_loop_ctrl;
    localparam int Size       = 3072;
    localparam int Size_bi    = 64;
    localparam int loop_round = 57;
    localparam int radix      = 54;
    localparam int TIMEOUT    = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    outer_loop_ctrl_if #(.Size(Size), .Size_bi(Size_bi)) bus ();

    outer_loop_ctrl #(
        .Size(Size), .Size_bi(Size_bi), .loop_round(loop_round),
        .radix(radix), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // per-round inner-loop latency in cycles after il_en; 0 = never answers
    int lat [loop_round];
    bit stray = 1'b0;
    int due = -1;

    // inner-loop model, plus optional stray completions in ISSUE and ACC
    always @(negedge clk) begin
        bus.il_en_out = 1'b0;
        if (!rst_n) begin
            due = -1;
        end else begin
            if (cyc == due) begin
                bus.il_en_out = 1'b1;
                due = -1;
            end
            if (bus.il_en) begin
                if (bus.round_idx < loop_round && lat[bus.round_idx] > 0)
                    due = cyc + lat[bus.round_idx];
                if (stray) bus.il_en_out = 1'b1;
            end
            if (bus.acc_en && stray) bus.il_en_out = 1'b1;
        end
    end

    // event recorder
    int          q_ie_c[$];
    logic [63:0] q_ie_bi[$];
    int          q_ac_c[$];
    int          q_ac_r[$];
    logic [63:0] q_ac_bi[$];
    int          q_dn[$];
    int          q_er[$];
    int          bad_bi = 0;
    logic        err_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.il_en === 1'b1) begin
            q_ie_c.push_back(cyc);
            q_ie_bi.push_back(bus.il_bi);
        end
        if (bus.acc_en === 1'b1) begin
            q_ac_c.push_back(cyc);
            q_ac_r.push_back(int'(bus.round_idx));
            q_ac_bi.push_back(bus.il_bi);
        end
        if (bus.done === 1'b1) q_dn.push_back(cyc);
        if (bus.err === 1'b1 && err_prev !== 1'b1) q_er.push_back(cyc);
        err_prev = bus.err;
        if ((bus.busy === 1'b0 || bus.done === 1'b1 || bus.err === 1'b1) && bus.il_bi !== '0)
            bad_bi++;
    end

    function automatic logic [63:0] slice_of(input logic [Size-1:0] v, input int r);
        logic [Size-1:0] sh;
        sh = v >> (radix * r);
        return sh[63:0] & ((64'd1 << radix) - 64'd1);
    endfunction

    function automatic logic [Size-1:0] rand_b();
        logic [Size-1:0] v;
        v = '0;
        for (int i = 0; i < Size / 32; i++) v = (v << 32) | Size'($urandom);
        return v;
    endfunction

    int op_s;

    // Run one operation from the current negedge. The expected event
    // schedule is built round by round: ISSUE at t, answer after lat cycles,
    // ACC one cycle later, next ISSUE at t+lat+2.
    task automatic do_op(input logic [Size-1:0] bv, input int ab_rnd,
                         input int rs_rnd, input int bs_rnd);
        int          t, fin, ab_c, rs_c, bs_c;
        int          e_ie_c[$];
        logic [63:0] e_bi[$];
        int          e_ac_c[$];
        int          e_dn[$];
        int          e_er[$];
        ab_c = -10; rs_c = -10; bs_c = -10;
        q_ie_c.delete(); q_ie_bi.delete(); q_ac_c.delete(); q_ac_r.delete();
        q_ac_bi.delete(); q_dn.delete(); q_er.delete(); bad_bi = 0;
        op_s = cyc;
        bus.b = bv;
        bus.start = 1'b1;
        t = op_s + 1;
        fin = -1;
        for (int r = 0; r < loop_round && fin < 0; r++) begin
            e_ie_c.push_back(t);
            e_bi.push_back(slice_of(bv, r));
            if (r == bs_rnd) bs_c = t + 1;
            if (r == rs_rnd) begin
                rs_c = t + 1; fin = rs_c;
            end else if (r == ab_rnd) begin
                ab_c = t + lat[r]; fin = ab_c;
            end else if (lat[r] == 0) begin
                e_er.push_back(t + TIMEOUT + 1); fin = t + TIMEOUT + 1;
            end else begin
                e_ac_c.push_back(t + lat[r] + 1);
                t += lat[r] + 2;
                if (r == loop_round - 1) begin
                    e_dn.push_back(t); fin = t;
                end
            end
        end
        while (cyc < fin + 4) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = 1'b0;
            bus.b = ~bv;
            if (cyc == bs_c) bus.start = 1'b1;
            if (cyc == ab_c) bus.abort = 1'b1;
            if (cyc == ab_c + 1) begin
                chk("abort_busy", bus.busy, 0);
                chk("abort_round", bus.round_idx, 0);
            end
            if (rs_c > 0 && cyc >= rs_c) rst_n = 1'b0;
        end
        chk("n_ilen", q_ie_c.size(), e_ie_c.size());
        chk("n_acc", q_ac_c.size(), e_ac_c.size());
        chk("n_done", q_dn.size(), e_dn.size());
        chk("n_err", q_er.size(), e_er.size());
        for (int i = 0; i < e_ie_c.size() && i < q_ie_c.size(); i++) begin
            chk($sformatf("ilen_cyc[%0d]", i), q_ie_c[i], e_ie_c[i]);
            chk($sformatf("ilbi[%0d]", i), q_ie_bi[i], e_bi[i]);
        end
        for (int i = 0; i < e_ac_c.size() && i < q_ac_c.size(); i++) begin
            chk($sformatf("acc_cyc[%0d]", i), q_ac_c[i], e_ac_c[i]);
            chk($sformatf("acc_round[%0d]", i), q_ac_r[i], i);
            chk($sformatf("acc_bi[%0d]", i), q_ac_bi[i], e_bi[i]);
        end
        if (e_dn.size() > 0 && q_dn.size() > 0) chk("done_cyc", q_dn[0], e_dn[0]);
        if (e_er.size() > 0 && q_er.size() > 0) chk("err_cyc", q_er[0], e_er[0]);
        chk("ilbi_idle_zero", bad_bi, 0);
    endtask

    task automatic rand_lat();
        for (int r = 0; r < loop_round; r++) lat[r] = $urandom_range(1, TIMEOUT);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_il_en"}, bus.il_en, 0);
        chk({tag, "_il_bi"}, bus.il_bi, 0);
        chk({tag, "_acc_en"}, bus.acc_en, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_round"}, bus.round_idx, 0);
    endtask

    initial begin
        logic [Size-1:0] bv;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.b = '0;
        bus.il_en_out = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outs("rst");

        // nominal: slice k holds k+1, answer after 5 cycles; start on the
        // first edge after reset release
        bv = '0;
        for (int k = 0; k < loop_round; k++) bv |= Size'(k + 1) << (radix * k);
        for (int r = 0; r < loop_round; r++) lat[r] = 5;
        rst_n = 1'b1;
        do_op(bv, -1, -1, -1);
        chk("nominal_latency", (q_dn.size() > 0) ? q_dn[0] - op_s : -1, 400);
        chk("nominal_err", bus.err, 0);

        // top slice only partly backed by b
        bv = rand_b();
        bv[Size-1 -: 48] = '1;
        rand_lat();
        do_op(bv, -1, -1, -1);
        chk("top_slice", (q_ie_bi.size() == loop_round) ? q_ie_bi[loop_round-1] : 64'hdead,
            64'h0000_FFFF_FFFF_FFFF);

        // timeout at round 3, then start clears err, then a fresh run
        rand_lat();
        lat[3] = 0;
        do_op(rand_b(), -1, -1, -1);
        chk("to_err", bus.err, 1);
        chk("to_busy", bus.busy, 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("to_clr_err", bus.err, 0);
        chk("to_clr_busy", bus.busy, 0);
        rand_lat();
        do_op(rand_b(), -1, -1, -1);

        // completion on the last timer cycle wins over the timeout
        for (int r = 0; r < loop_round; r++) lat[r] = TIMEOUT;
        do_op(rand_b(), -1, -1, -1);

        // abort in round 10 together with the completion pulse
        rand_lat();
        do_op(rand_b(), 10, -1, -1);

        // busy start in round 5, reset in round 20, then a fresh run
        rand_lat();
        do_op(rand_b(), -1, 20, 5);
        chk_idle_outs("midrst");
        rst_n = 1'b1;
        rand_lat();
        do_op(rand_b(), -1, -1, -1);

        // random runs with stray completions outside WAIT
        stray = 1'b1;
        for (int n = 0; n < 2; n++) begin
            rand_lat();
            do_op(rand_b(), -1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
